// File: rtl/pulse_burst_ctrl.sv
// Burst sequencer for the jittered pulse source: gates en_o for reps bursts of pulses, gap clocks apart.
// Optional watchdog (macro PULSE_BURST_TMO_EN) aborts a run that sees no pulse for TMO_CYC clocks.
module pulse_burst_ctrl #(
  parameter int CNT_W   = 8,
  parameter int GAP_W   = 12,
  parameter int REP_W   = 4,
  parameter int TMO_CYC = 1000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] pulses_i,
  input  logic [GAP_W-1:0] gap_i,
  input  logic [REP_W-1:0] reps_i,
  input  logic             pulse_i,
  output logic             en_o,
  output logic             pulse_o,
  output logic             busy_o,
  output logic             burst_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic [REP_W-1:0] rcnt_q, rcnt_d;
  logic [CNT_W-1:0] pulses_q, pulses_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             en_q, en_d;
  logic             pulse_q, pulse_d;
  logic             burst_q, burst_d;
  logic             done_q, done_d;

`ifdef PULSE_BURST_TMO_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] wcnt_q, wcnt_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    gcnt_d   = gcnt_q;
    rcnt_d   = rcnt_q;
    pulses_d = pulses_q;
    gap_d    = gap_q;
    pulse_d  = 1'b0;
    burst_d  = 1'b0;
    done_d   = 1'b0;
`ifdef PULSE_BURST_TMO_EN
    wcnt_d   = '0;
    err_d    = err_q;
`endif
    // abort outranks start and any same-cycle pulse
    if (abort_i) begin
      state_d = IDLE;
      pcnt_d  = '0;
      gcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            pulses_d = pulses_i;
            gap_d    = gap_i;
            rcnt_d   = reps_i;
            pcnt_d   = '0;
`ifdef PULSE_BURST_TMO_EN
            err_d    = 1'b0;
`endif
            if (pulses_i == '0 || reps_i == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
`ifdef PULSE_BURST_TMO_EN
          wcnt_d = wcnt_q + TMO_W'(1);
`endif
          if (pulse_i) begin
            pulse_d = 1'b1;
`ifdef PULSE_BURST_TMO_EN
            wcnt_d  = '0;
`endif
            if (pcnt_q == pulses_q - CNT_W'(1)) begin
              burst_d = 1'b1;
              pcnt_d  = '0;
              rcnt_d  = rcnt_q - REP_W'(1);
              if (rcnt_q == REP_W'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end else if (gap_q != '0) begin
                state_d = GAP;
                gcnt_d  = gap_q;
              end
            end else begin
              pcnt_d = pcnt_q + CNT_W'(1);
            end
          end
`ifdef PULSE_BURST_TMO_EN
          else if (wcnt_q == TMO_W'(TMO_CYC - 1)) begin
            err_d   = 1'b1;
            state_d = IDLE;
            pcnt_d  = '0;
          end
`endif
        end
        GAP: begin
          if (gcnt_q == GAP_W'(1)) begin
            state_d = RUN;
          end else begin
            gcnt_d = gcnt_q - GAP_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // en follows the next state so it drops on the same clock as burst_o
    en_d = (state_d == RUN);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      pcnt_q   <= '0;
      gcnt_q   <= '0;
      rcnt_q   <= '0;
      pulses_q <= '0;
      gap_q    <= '0;
      en_q     <= 1'b0;
      pulse_q  <= 1'b0;
      burst_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      gcnt_q   <= gcnt_d;
      rcnt_q   <= rcnt_d;
      pulses_q <= pulses_d;
      gap_q    <= gap_d;
      en_q     <= en_d;
      pulse_q  <= pulse_d;
      burst_q  <= burst_d;
      done_q   <= done_d;
    end
  end

`ifdef PULSE_BURST_TMO_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      err_q  <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign en_o    = en_q;
  assign pulse_o = pulse_q;
  assign busy_o  = (state_q != IDLE);
  assign burst_o = burst_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_pulse_burst_ctrl.sv
// Scoreboard bench for pulse_burst_ctrl: stimulus queues expected pulse/burst/done events, a negedge monitor retires them.
module tb_pulse_burst_ctrl;
  localparam int CNT_W   = 8;
  localparam int GAP_W   = 12;
  localparam int REP_W   = 4;
  localparam int TMO_CYC = 20;
  localparam int EV_P = 1, EV_B = 2, EV_D = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0, abort = 1'b0, pin = 1'b0;
  logic [CNT_W-1:0] pulses = '0;
  logic [GAP_W-1:0] gap = '0;
  logic [REP_W-1:0] reps = '0;
  logic             en, pout, busy, burst, done, err;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int expq[$];

  pulse_burst_ctrl #(
    .CNT_W(CNT_W), .GAP_W(GAP_W), .REP_W(REP_W), .TMO_CYC(TMO_CYC)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .pulses_i(pulses), .gap_i(gap), .reps_i(reps), .pulse_i(pin),
    .en_o(en), .pulse_o(pout), .busy_o(busy), .burst_o(burst),
    .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input int at);
    expq.push_back(kind * 1000000 + at);
  endtask

  task automatic check_ev(input int kind);
    int e;
    n_tests++;
    if (expq.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected no event", kind, cyc);
    end else begin
      e = expq.pop_front();
      if (e != kind * 1000000 + cyc) begin
        n_fail++;
        $display("FAIL event_order: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                 kind, cyc, e / 1000000, e % 1000000);
      end
    end
  endtask

  // event order within one clock: pulse, burst, done
  always @(negedge clk) begin
    if (!rst) begin
      if (pout)  check_ev(EV_P);
      if (burst) check_ev(EV_B);
      if (done)  check_ev(EV_D);
    end
  end

  task automatic tick(input logic s, input logic a, input logic p);
    start = s; abort = a; pin = p;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; pin = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic cfg(input int p, input int g, input int r);
    pulses = CNT_W'(p); gap = GAP_W'(g); reps = REP_W'(r);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {pout, burst, done, err}, 0);
    rst = 1'b0;
    idle(2);

    // 3 pulses x 2 bursts, gap 5, source pulse every 8 clocks
    cfg(3, 5, 2);
    tick(1, 0, 0);
    chk("t1_en_start", en, 1);
    chk("t1_busy_start", busy, 1);
    for (int i = 0; i < 3; i++) begin
      idle(7);
      expect_ev(EV_P, cyc + 1);
      if (i == 2) expect_ev(EV_B, cyc + 1);
      tick(0, 0, 1);
    end
    for (int i = 0; i < 5; i++) begin
      chk("t1_gap_en_low", en, 0);
      idle(1);
    end
    chk("t1_gap_en_back", en, 1);
    idle(2);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) idle(7);
      expect_ev(EV_P, cyc + 1);
      if (i == 2) begin
        expect_ev(EV_B, cyc + 1);
        expect_ev(EV_D, cyc + 1);
      end
      tick(0, 0, 1);
    end
    chk("t1_busy_end", busy, 0);
    chk("t1_en_end", en, 0);

    // zero pulses: immediate done, started on the very clock done was seen
    cfg(0, 2, 4);
    expect_ev(EV_D, cyc + 1);
    tick(1, 0, 0);
    chk("t2_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 1);
      chk("t2_en_never", en, 0);
    end

    // abort together with the 2nd pulse
    cfg(4, 1, 1);
    tick(1, 0, 0);
    idle(2);
    expect_ev(EV_P, cyc + 1);
    tick(0, 0, 1);
    idle(2);
    tick(0, 1, 1);
    chk("t3_en_abort", en, 0);
    chk("t3_busy_abort", busy, 0);
    idle(4);

    // gap 0: en continuous, back-to-back pulses
    cfg(2, 0, 3);
    tick(1, 0, 0);
    chk("t4_en_start", en, 1);
    for (int i = 0; i < 6; i++) begin
      expect_ev(EV_P, cyc + 1);
      if (i % 2 == 1) expect_ev(EV_B, cyc + 1);
      if (i == 5) expect_ev(EV_D, cyc + 1);
      tick(0, 0, 1);
      if (i < 5) chk("t4_en_cont", en, 1);
    end
    chk("t4_en_end", en, 0);
    chk("t4_busy_end", busy, 0);
    idle(2);

    // start while busy ignored; pulse during gap dropped
    cfg(2, 3, 2);
    tick(1, 0, 0);
    cfg(1, 0, 1);
    tick(1, 0, 0);
    cfg(7, 7, 7);
    expect_ev(EV_P, cyc + 1);
    tick(0, 0, 1);
    expect_ev(EV_P, cyc + 1);
    expect_ev(EV_B, cyc + 1);
    tick(0, 0, 1);
    chk("t5_en_gap", en, 0);
    tick(0, 0, 1);
    idle(1);
    chk("t5_en_gap_late", en, 0);
    idle(1);
    chk("t5_en_run2", en, 1);
    expect_ev(EV_P, cyc + 1);
    tick(0, 0, 1);
    expect_ev(EV_P, cyc + 1);
    expect_ev(EV_B, cyc + 1);
    expect_ev(EV_D, cyc + 1);
    tick(0, 0, 1);
    chk("t5_busy_end", busy, 0);
    idle(2);

    // abort beats start in IDLE
    cfg(1, 0, 1);
    tick(1, 1, 0);
    chk("t6_abort_start_busy", busy, 0);
    chk("t6_abort_start_en", en, 0);
    idle(2);

`ifdef PULSE_BURST_TMO_EN
    cfg(3, 0, 1);
    tick(1, 0, 0);
    idle(19);
    chk("t7_err_early", err, 0);
    chk("t7_en_early", en, 1);
    idle(1);
    chk("t7_err_set", err, 1);
    chk("t7_en_tmo", en, 0);
    chk("t7_busy_tmo", busy, 0);
    idle(3);
    chk("t7_err_sticky", err, 1);
    cfg(0, 0, 1);
    expect_ev(EV_D, cyc + 1);
    tick(1, 0, 0);
    chk("t7_err_clear", err, 0);
    idle(2);
`endif

    idle(3);
    chk("queue_drained", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pulse_burst_ctrl.md
# pulse_burst_ctrl

Sequencer for the tuner's jittered pulse source. It gates the source enable to produce a programmed number of bursts. Each burst contains a programmed number of pulses, and bursts are separated by a programmed idle gap. It sits between the tuner register interface (start/abort, burst config) and one jittered pulse generator. It counts returned pulses and forwards them as a gated pulse stream with burst/done status.

## Interface
- CNT_W, 8, width of pulses-per-burst count
- GAP_W, 12, width of inter-burst gap count (clocks)
- REP_W, 4, width of burst repeat count
- TMO_CYC, 1000, watchdog limit in clocks without a pulse while running (timeout build only)

- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  start request, single-cycle strobe
- abort_i  in  1  abort request, single-cycle strobe
- pulses_i  in  CNT_W  pulses per burst
- gap_i  in  GAP_W  idle clocks between bursts
- reps_i  in  REP_W  number of bursts
- pulse_i  in  1  single-cycle pulse from the jittered pulse source
- en_o  out  1  enable to the pulse source
- pulse_o  out  1  gated, registered copy of counted pulses
- busy_o  out  1  high in any state other than IDLE
- burst_o  out  1  single-cycle strobe at the end of each burst
- done_o  out  1  single-cycle strobe on normal completion of all bursts
- err_o  out  1  sticky watchdog error flag

## Operation
- States are IDLE, RUN and GAP. All outputs are registered.
- Config (pulses_i, gap_i, reps_i) is latched on an accepted start. Config inputs are ignored at all other times.
- IDLE behaviour:
  - start_i accepted only in IDLE. start_i while busy_o=1 is ignored.
  - If the latched pulses==0 or reps==0: stay IDLE, pulse done_o next cycle, en_o never asserted.
  - Otherwise go to RUN.
- RUN behaviour:
  - en_o=1.
  - Each pulse_i increments the pulse counter and produces pulse_o one clock later.
  - When the count reaches pulses: pulse burst_o, decrement the remaining-bursts count, clear the pulse counter, drop en_o.
  - If bursts remain and gap>0, go to GAP.
  - If bursts remain and gap==0, stay in RUN; en_o stays high and the next burst starts immediately.
  - If no bursts remain, go to IDLE and pulse done_o in the same cycle as burst_o.
- GAP behaviour: en_o=0. A gap counter loads gap and counts down. On the cycle it reaches 1, go to RUN.
- pulse_i outside RUN is ignored. The source may emit a trailing pulse after en_o falls; it is not counted or forwarded.
- Counter widths: pulse counter is CNT_W bits, gap counter GAP_W, burst counter REP_W. No counter wraps because terminal compares stop every counter first.
- abort_i:
  - From any state, go to IDLE next cycle. en_o drops next cycle.
  - No done_o and no burst_o are generated.
  - abort_i wins over a pulse_i in the same cycle; that pulse is not forwarded.
  - abort_i wins over start_i in the same cycle.
- Reset values: IDLE, and en_o, pulse_o, busy_o, burst_o, done_o, err_o all 0. Reset mid-burst discards all counts.

## Timing
- start_i high at edge t (IDLE, valid config): busy_o=1 and en_o=1 from t+1.
- pulse_i at edge k in RUN: pulse_o=1 at k+1 for exactly one clock.
- Last pulse of a burst at edge k: burst_o=1 and en_o=0 at k+1. Exception: gap==0 with bursts remaining, where en_o stays 1.
- GAP lasts exactly gap clocks with en_o=0. en_o returns to 1 on clock k+1+gap.
- Final burst: done_o=1 and busy_o=0 at k+1. A new start_i is accepted at k+1.
- Back-to-back pulse_i on consecutive clocks are each counted.

## Configuration
- Macro: PULSE_BURST_TMO_EN.
- Defined:
  - A watchdog counter runs in RUN only. It clears on entry to RUN and on every counted pulse.
  - When it reaches TMO_CYC: set err_o, go to IDLE, en_o=0, no done_o.
  - err_o is sticky and clears on the next accepted start_i.
- Undefined: no watchdog logic, err_o tied to 0, TMO_CYC unused.

## Test plan
- pulses=3, reps=2, gap=5, start at t=10, source pulses every 8 clocks:
  - exactly 6 pulse_o;
  - burst_o twice;
  - en_o low for exactly 5 clocks between bursts;
  - done_o once, on the same clock as the second burst_o.
- pulses=0, reps=4: done_o one clock after start, en_o never 1, no pulse_o.
- pulses=4, reps=1, abort_i on the same clock as the 2nd pulse_i:
  - 1 pulse_o only;
  - en_o and busy_o low the next clock;
  - no done_o, no burst_o.
- pulses=2, reps=3, gap=0: en_o stays high continuously, 6 pulse_o, 3 burst_o, 1 done_o.
- start_i strobed while busy with different config: ignored, original run completes unchanged. A pulse_i injected during GAP is not forwarded.
- PULSE_BURST_TMO_EN, TMO_CYC=20:
  - hold pulse_i low after start: err_o=1 and en_o=0 at 20 clocks after RUN entry, no done_o;
  - the next start clears err_o.
